// File: rtl/piso_shift_transmitter.sv
// Parallel-in / serial-out transmitter. Sends WIDTH-bit frames LSB-first (mode 0) or MSB-first (mode 1).
// Optional macro PISO_SHIFT_PARITY_EN appends an even-parity bit to each frame.
module piso_shift_transmitter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             SO,
  output logic             SO_vld,
  output logic             done,
  output logic [WIDTH-1:0] SR
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_SHIFT_PARITY_EN
  // The parity bit occupies the extra slot counted as index WIDTH.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             mode_reg, mode_next;
  logic [WIDTH-1:0] sr_rsh, sr_lsh;

`ifdef PISO_SHIFT_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  assign sr_rsh = {1'b0, sr_reg[WIDTH-1:1]};
  assign sr_lsh = {sr_reg[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      sr_reg     <= '0;
      cnt_reg    <= '0;
      mode_reg   <= 1'b0;
`ifdef PISO_SHIFT_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      sr_reg     <= sr_next;
      cnt_reg    <= cnt_next;
      mode_reg   <= mode_next;
`ifdef PISO_SHIFT_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    sr_next     = sr_reg;
    cnt_next    = cnt_reg;
    mode_next   = mode_reg;
`ifdef PISO_SHIFT_PARITY_EN
    parity_next = parity_reg;
`endif
    ready  = 1'b0;
    SO     = 1'b0;
    SO_vld = 1'b0;
    done   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (load) begin
          sr_next     = din;
          mode_next   = mode;
          cnt_next    = '0;
`ifdef PISO_SHIFT_PARITY_EN
          parity_next = ^din;
`endif
          state_next  = SHIFT;
        end
      end

      SHIFT: begin
        SO_vld  = 1'b1;
        SO      = mode_reg ? sr_reg[WIDTH-1] : sr_reg[0];
`ifdef PISO_SHIFT_PARITY_EN
        if (cnt_reg == CW'(WIDTH)) begin
          SO = parity_reg;
        end
`endif
        // Data is fully drained after WIDTH shifts, so shifting during the
        // parity slot only moves zeros and SR still reads 0 in DONE.
        sr_next = mode_reg ? sr_lsh : sr_rsh;
        // Counter holds on the final slot so it never exceeds its range.
        if (cnt_reg == LAST_CNT) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign SR = sr_reg;

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Directed bench for piso_shift_transmitter (WIDTH=4); expected bit streams are hand-computed.
// Works in both the default build and with PISO_SHIFT_PARITY_EN defined.
module tb_piso_shift_transmitter;

`ifdef PISO_SHIFT_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk;
  logic       rst;
  logic       load;
  logic       mode;
  logic [3:0] din;
  logic       ready;
  logic       SO;
  logic       SO_vld;
  logic       done;
  logic [3:0] SR;

  int errors = 0;
  int checks = 0;

  piso_shift_transmitter #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .mode   (mode),
    .din    (din),
    .ready  (ready),
    .SO     (SO),
    .SO_vld (SO_vld),
    .done   (done),
    .SR     (SR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a load for one edge and confirm capture.
  task automatic start(input string tag, input logic [3:0] d, input logic m);
    load = 1'b1;
    din  = d;
    mode = m;
    tick();
    chk({tag, "_sr_cap"}, SR, d);
    chk({tag, "_busy"}, ready, 1'b0);
  endtask

  // seq[i] is the i-th bit expected on SO; seq[4] is the parity bit.
  task automatic bits(input string tag, input logic [4:0] seq);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("%s_vld%0d", tag, i), SO_vld, 1'b1);
      chk($sformatf("%s_so%0d", tag, i), SO, seq[i]);
      chk($sformatf("%s_rdy%0d", tag, i), ready, 1'b0);
      chk($sformatf("%s_done%0d", tag, i), done, 1'b0);
      tick();
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_done_vld"}, SO_vld, 1'b0);
    chk({tag, "_done_so"}, SO, 1'b0);
    chk({tag, "_done_rdy"}, ready, 1'b0);
    chk({tag, "_done_sr"}, SR, 4'b0000);
    tick();
    chk({tag, "_idle_done"}, done, 1'b0);
    chk({tag, "_idle_rdy"}, ready, 1'b1);
    chk({tag, "_idle_vld"}, SO_vld, 1'b0);
    $display("frame %s din=%b complete", tag, din);
  endtask

  initial begin
    rst  = 1'b0;
    load = 1'b0;
    mode = 1'b0;
    din  = 4'b0000;

    #2;
    chk("rst_ready", ready, 1'b1);
    chk("rst_so", SO, 1'b0);
    chk("rst_vld", SO_vld, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sr", SR, 4'b0000);

    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    chk("idle_ready", ready, 1'b1);
    chk("idle_vld", SO_vld, 1'b0);

    // LSB first: 1011 -> 1,1,0,1 (+ parity 1)
    start("m0", 4'b1011, 1'b0);
    load = 1'b0;
    bits("m0", 5'b11011);

    // MSB first: 1011 -> 1,0,1,1; mode flipped after load must not matter
    start("m1", 4'b1011, 1'b1);
    load = 1'b0;
    mode = 1'b0;
    bits("m1", 5'b11101);

    // Load held with a new word during the frame; second frame starts only from IDLE
    start("hold", 4'b1011, 1'b0);
    din  = 4'b0110;
    mode = 1'b1;
    bits("hold", 5'b11011);
    tick();
    chk("hold2_sr_cap", SR, 4'b0110);
    chk("hold2_busy", ready, 1'b0);
    load = 1'b0;
    // MSB first: 0110 -> 0,1,1,0 (+ parity 0)
    bits("hold2", 5'b00110);

    // Reset during the third bit aborts the frame
    start("abort", 4'b1011, 1'b0);
    load = 1'b0;
    chk("abort_so0", SO, 1'b1);
    tick();
    chk("abort_so1", SO, 1'b1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("abort_ready", ready, 1'b1);
    chk("abort_so", SO, 1'b0);
    chk("abort_vld", SO_vld, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sr", SR, 4'b0000);
    tick();
    chk("abort_hold_done0", done, 1'b0);
    tick();
    chk("abort_hold_done1", done, 1'b0);
    rst = 1'b1;
    // First edge after release accepts the load: 0001 -> 1,0,0,0 (+ parity 1)
    start("post", 4'b0001, 1'b0);
    load = 1'b0;
    bits("post", 5'b10001);

    // 0011 -> 1,1,0,0 (+ parity 0)
    start("par0", 4'b0011, 1'b0);
    load = 1'b0;
    bits("par0", 5'b00011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
